iadc_conv_ctrl: RTL

Conversion sequencer for the incremental ADC first-stage datapath. On a start request it clears the 1-bit-input integrator, enables the modulator/integrator for exactly OSR clock cycles, then captures the integrator output as the conversion result. It provides a start/busy/valid handshake to the decimation and readout logic and supports abort. It sits between the system control interface and the modulator + integrator pair.

---
 rtl/iadc_conv_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/iadc_conv_ctrl.sv
// ---------------------------------------------------------------------------
// iadc_conv_ctrl
// Conversion sequencer for the incremental ADC first stage. A start request
// clears the integrator, enables the modulator/integrator for exactly OSR
// cycles, and then latches the integrator output as the conversion result.
// An abort returns to IDLE without producing a result.
//
// Parameters:
//   OSR         number of enabled integration cycles per conversion (2..65536)
//   W           integrator/result width, 2^W > OSR
//   CLR_CYCLES  cycles int_clr is held before integration (1..15)
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   start         conversion request, sampled only in IDLE
//   abort         cancel a running conversion (wins over start)
//   int_data      registered integrator output
//   int_clr       integrator clear
//   mod_en        modulator/integrator enable
//   busy          conversion in progress (CLEAR, CONVERT, CAPTURE)
//   result        last completed conversion value
//   result_valid  one-cycle pulse when result updates
// ---------------------------------------------------------------------------
module iadc_conv_ctrl #(
    parameter int OSR        = 256,
    parameter int W          = 9,
    parameter int CLR_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] int_data,
    output logic         int_clr,
    output logic         mod_en,
    output logic         busy,
    output logic [W-1:0] result,
    output logic         result_valid
);

    localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CLEAR   = 2'd1;
    localparam logic [1:0] S_CONVERT = 2'd2;
    localparam logic [1:0] S_CAPTURE = 2'd3;

    logic [1:0]    state, state_nxt;
    logic [3:0]    clr_cnt;
    logic [CW-1:0] smp_cnt;
    logic          capture_done;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start && !abort) state_nxt = S_CLEAR;
            S_CLEAR: begin
                if (abort)                                 state_nxt = S_IDLE;
                else if (clr_cnt == 4'(CLR_CYCLES - 1))    state_nxt = S_CONVERT;
            end
            S_CONVERT: begin
                if (abort)                                 state_nxt = S_IDLE;
                else if (smp_cnt == CW'(OSR - 1))          state_nxt = S_CAPTURE;
            end
            default:   state_nxt = S_IDLE;
        endcase
    end

    // A capture completes only if the CAPTURE cycle is not aborted.
    assign capture_done = (state == S_CAPTURE) && !abort;

    // Outputs are registered from the next-state decode so they line up
    // with the state they describe and never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            clr_cnt      <= '0;
            smp_cnt      <= '0;
            int_clr      <= 1'b0;
            mod_en       <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            // Counters restart at 0 whenever the state is (re)entered.
            clr_cnt      <= (state == S_CLEAR && state_nxt == S_CLEAR)
                            ? clr_cnt + 4'd1 : 4'd0;
            smp_cnt      <= (state == S_CONVERT && state_nxt == S_CONVERT)
                            ? smp_cnt + CW'(1) : '0;
            int_clr      <= (state_nxt == S_CLEAR);
            mod_en       <= (state_nxt == S_CONVERT);
            busy         <= (state_nxt != S_IDLE);
            result_valid <= capture_done;
            if (capture_done)
                result <= int_data;
        end
    end

endmodule
